// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - AXI read address/data channel bundle for the read arbiter
//
// Purpose: groups the AR and R channel signals of one AXI read port.
// Modports:
//   master : arbiter side, drives AR payload/valid and rready
//   slave  : memory side, drives arready and the R payload/valid
interface axi_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic              arvalid;
    logic              arready;
    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - single-outstanding AXI read arbiter for fetch (inst) and load (data) requesters
//
// Purpose: shares one AXI read port between the fetch and load front ends.
//   One single-beat read is in flight at a time; the R beat is routed back to
//   the requester that owns it as a registered one-cycle pulse. Loads win over
//   fetches unless fetches have been passed over STARVE_MAX times in a row.
// Ports:
//   aclk, areset                 clock, synchronous active-high reset
//   inst_req/addr/cancel         fetch request side (inputs)
//   inst_addr_ok/valid/rdata/exception  fetch accept and response (outputs)
//   data_req/addr/cancel         load request side (inputs)
//   data_addr_ok/data_ok/rdata/exception  load accept and response (outputs)
//   axi                          AR/R channels (master modport)
module axi_rd_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_cancel,
    output logic              inst_addr_ok,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_exception,

    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_cancel,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_exception,

    axi_rd_arbiter_if.master  axi
);

    localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;          // 1 = data, 0 = inst
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              cancel_pend_q, cancel_pend_d;
    logic              inst_valid_q, inst_valid_d;
    logic              data_ok_q, data_ok_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              exc_q, exc_d;

    logic              grant_data;
    logic              grant_inst;
    logic              own_cancel;

    // rid is checked externally, rlast is meaningless for single beats and
    // rresp[0] (EXOKAY) carries nothing for these requesters.
    logic              unused_r;
    assign unused_r = ^{axi.rid, axi.rlast, axi.rresp[0]};

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        starve_d      = starve_q;
        cancel_pend_d = cancel_pend_q;
        inst_valid_d  = 1'b0;
        data_ok_d     = 1'b0;
        rdata_d       = '0;
        exc_d         = 1'b0;
        grant_data    = 1'b0;
        grant_inst    = 1'b0;
        own_cancel    = owner_q ? data_cancel : inst_cancel;

        case (state_q)
            S_IDLE: begin
                if (data_req && (!inst_req || (starve_q < STARVE_LIM))) begin
                    grant_data = 1'b1;
                end else if (inst_req) begin
                    grant_inst = 1'b1;
                end
                if (grant_data || grant_inst) begin
                    owner_d       = grant_data;
                    addr_d        = grant_data ? data_addr : inst_addr;
                    // A cancel arriving together with the grant still counts.
                    cancel_pend_d = grant_data ? data_cancel : inst_cancel;
                    state_d       = S_AR;
                end
            end
            S_AR: begin
                if (own_cancel) cancel_pend_d = 1'b1;
                if (axi.arready) state_d = S_R;
            end
            S_R: begin
                if (own_cancel) cancel_pend_d = 1'b1;
                if (axi.rvalid) begin
                    state_d       = S_IDLE;
                    cancel_pend_d = 1'b0;
                    // A cancel in the handshake cycle itself also drops the beat.
                    if (!(cancel_pend_q || own_cancel)) begin
                        inst_valid_d = !owner_q;
                        data_ok_d    = owner_q;
                        rdata_d      = axi.rdata;
                        exc_d        = axi.rresp[1];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Counts loads that jumped ahead of a waiting fetch.
        if (!inst_req || grant_inst) begin
            starve_d = '0;
        end else if (grant_data && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= S_IDLE;
            owner_q       <= 1'b0;
            addr_q        <= '0;
            starve_q      <= '0;
            cancel_pend_q <= 1'b0;
            inst_valid_q  <= 1'b0;
            data_ok_q     <= 1'b0;
            rdata_q       <= '0;
            exc_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            starve_q      <= starve_d;
            cancel_pend_q <= cancel_pend_d;
            inst_valid_q  <= inst_valid_d;
            data_ok_q     <= data_ok_d;
            rdata_q       <= rdata_d;
            exc_q         <= exc_d;
        end
    end

    // Grants are combinational; hold them off while reset is asserted.
    assign inst_addr_ok   = grant_inst && !areset;
    assign data_addr_ok   = grant_data && !areset;

    assign inst_valid     = inst_valid_q;
    assign inst_rdata     = inst_valid_q ? rdata_q : '0;
    assign inst_exception = inst_valid_q & exc_q;
    assign data_data_ok   = data_ok_q;
    assign data_rdata     = data_ok_q ? rdata_q : '0;
    assign data_exception = data_ok_q & exc_q;

    assign axi.arid    = {3'b000, owner_q};
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = 3'd2;
    assign axi.arvalid = (state_q == S_AR);
    assign axi.rready  = (state_q == S_R);

endmodule
